// File: rtl/xadc_drp_sampler_pkg.sv
// xadc_pkg: FSM encoding, DRP addresses and data widths shared by the XADC sampler.
package xadc_pkg;
    localparam int CODE_W = 12;
    localparam int MV_W = 16;
    localparam logic [7:0] VAUX0_ADDR = 8'h10;
    localparam logic [7:0] VAUX1_ADDR = 8'h11;
    localparam logic [7:0] VAUX8_ADDR = 8'h18;
    localparam logic [7:0] VAUX9_ADDR = 8'h19;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, SCALE, NEXT, PUBLISH} state_t;
endpackage

// File: rtl/xadc_drp_sampler_if.sv
// xadc_drp_sampler_if: XADC dynamic reconfiguration port, master side is the sampler.
interface xadc_drp_sampler_if;
    logic [6:0]  drp_daddr;
    logic        drp_den;
    logic        drp_dwe;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_drdy;
    modport master(output drp_daddr, drp_den, drp_dwe, drp_di, input drp_do, drp_drdy);
    modport slave(input drp_daddr, drp_den, drp_dwe, drp_di, output drp_do, drp_drdy);
endinterface

// File: rtl/xadc_drp_sampler_code_to_mv.sv
// xadc_code_to_mv: registered 12-bit XADC code to millivolts, rounded to nearest.
module xadc_code_to_mv
    import xadc_pkg::*;
#(
    parameter int FULL_SCALE_MV = 1000
)(
    input  logic              clk,
    input  logic              rstn,
    input  logic [CODE_W-1:0] code_i,
    output logic [MV_W-1:0]   mv_o
);
    logic [21:0] prod;
    assign prod = 22'(code_i) * 22'(FULL_SCALE_MV) + 22'd2048;
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) mv_o <= '0;
        else mv_o <= MV_W'(prod >> 12);
endmodule

// File: rtl/xadc_drp_sampler.sv
// xadc_drp_sampler: polls four XADC channels over DRP after each eos and publishes millivolts.
// Optional multi-sweep averaging is enabled by defining XADC_AVG_EN.
module xadc_drp_sampler
    import xadc_pkg::*;
#(
`ifdef XADC_AVG_EN
    parameter int AVG_LOG2 = 2,
`endif
    parameter logic [7:0] CH0_ADDR = VAUX1_ADDR,
    parameter logic [7:0] CH1_ADDR = VAUX0_ADDR,
    parameter logic [7:0] CH2_ADDR = VAUX8_ADDR,
    parameter logic [7:0] CH3_ADDR = VAUX9_ADDR,
    parameter int FULL_SCALE_MV = 1000,
    parameter int TIMEOUT_CYC = 255
)(
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     eos,
    xadc_drp_sampler_if.master       drp,
    output logic [MV_W-1:0]          dout0,
    output logic [MV_W-1:0]          dout1,
    output logic [MV_W-1:0]          dout2,
    output logic [MV_W-1:0]          dout3,
    output logic                     dout_valid,
    output logic                     drp_err
);
    localparam int WCNT_W = $clog2(TIMEOUT_CYC + 1);
`ifdef XADC_AVG_EN
    localparam int ACC_W = MV_W + AVG_LOG2;
    localparam logic [ACC_W-1:0] RND = ACC_W'((1 << AVG_LOG2) >> 1);
`else
    localparam int ACC_W = MV_W;
`endif
    state_t              state_q;
    logic [1:0]          ch_q;
    logic [1:0]          ch_nx;
    logic                pend_q;
    logic                to_q;
    logic [WCNT_W-1:0]   wcnt_q;
    logic [CODE_W-1:0]   code_q;
    logic [6:0]          daddr_q;
    logic                den_q;
    logic [MV_W-1:0]     mv;
    logic [MV_W-1:0]     add_mv;
    logic [ACC_W-1:0]    acc_d;
    logic [MV_W-1:0]     last_q [4];
    logic [ACC_W-1:0]    acc_q [4];
    logic [3:0][6:0]     addr;
    logic                pub;
    logic                unused_do;

    assign addr = {CH3_ADDR[6:0], CH2_ADDR[6:0], CH1_ADDR[6:0], CH0_ADDR[6:0]};
    assign ch_nx = ch_q + 2'd1;
    // A timed-out read re-uses the channel's last good value so the sum stays meaningful.
    assign add_mv = to_q ? last_q[ch_q] : mv;
    assign acc_d = acc_q[ch_q] + ACC_W'(add_mv);
    assign drp.drp_daddr = daddr_q;
    assign drp.drp_den = den_q;
    assign drp.drp_dwe = 1'b0;
    assign drp.drp_di = '0;
    assign unused_do = ^drp.drp_do[3:0];

`ifdef XADC_AVG_EN
    logic [4:0] swp_q;
    assign pub = swp_q == 5'((1 << AVG_LOG2) - 1);
    function automatic logic [MV_W-1:0] scale_out(logic [ACC_W-1:0] a);
        return MV_W'((a + RND) >> AVG_LOG2);
    endfunction
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) swp_q <= '0;
        else if (state_q == PUBLISH) swp_q <= pub ? 5'd0 : swp_q + 5'd1;
`else
    assign pub = 1'b1;
    function automatic logic [MV_W-1:0] scale_out(logic [ACC_W-1:0] a);
        return a;
    endfunction
`endif

    xadc_code_to_mv #(.FULL_SCALE_MV(FULL_SCALE_MV)) u_c2m (
        .clk(clk),
        .rstn(rstn),
        .code_i(code_q),
        .mv_o(mv)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            ch_q <= '0;
            pend_q <= 1'b0;
            to_q <= 1'b0;
            wcnt_q <= '0;
            code_q <= '0;
            daddr_q <= '0;
            den_q <= 1'b0;
            dout0 <= '0;
            dout1 <= '0;
            dout2 <= '0;
            dout3 <= '0;
            dout_valid <= 1'b0;
            drp_err <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                acc_q[i] <= '0;
                last_q[i] <= '0;
            end
        end else begin
            den_q <= 1'b0;
            dout_valid <= 1'b0;
            if (eos && state_q != IDLE) pend_q <= 1'b1;
            case (state_q)
                IDLE: if (eos || pend_q) begin
                    pend_q <= 1'b0;
                    ch_q <= '0;
                    daddr_q <= addr[0];
                    den_q <= 1'b1;
                    state_q <= REQ;
                end
                REQ: begin
                    wcnt_q <= '0;
                    to_q <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: if (drp.drp_drdy) begin
                    code_q <= drp.drp_do[15:4];
                    state_q <= SCALE;
                end else if (wcnt_q == WCNT_W'(TIMEOUT_CYC - 1)) begin
                    to_q <= 1'b1;
                    drp_err <= 1'b1;
                    state_q <= NEXT;
                end else wcnt_q <= wcnt_q + 1'b1;
                SCALE: state_q <= NEXT;
                NEXT: begin
                    acc_q[ch_q] <= acc_d;
                    last_q[ch_q] <= add_mv;
                    if (ch_q != 2'd3) begin
                        ch_q <= ch_nx;
                        daddr_q <= addr[ch_nx];
                        den_q <= 1'b1;
                        state_q <= REQ;
                    end else state_q <= PUBLISH;
                end
                PUBLISH: begin
                    if (pub) begin
                        dout0 <= scale_out(acc_q[0]);
                        dout1 <= scale_out(acc_q[1]);
                        dout2 <= scale_out(acc_q[2]);
                        dout3 <= scale_out(acc_q[3]);
                        dout_valid <= 1'b1;
                        for (int i = 0; i < 4; i++) acc_q[i] <= '0;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xadc_drp_sampler.sv
// tb_xadc_drp_sampler: directed sweeps against a DRP responder model, checked by a scoreboard.
module tb_xadc_drp_sampler;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic eos = 1'b0;
    logic [15:0] dout0, dout1, dout2, dout3;
    logic dout_valid, drp_err;
    logic [3:0][15:0] exp_q[$];
    logic [6:0] addr_q[$];
    logic [3:0][15:0] e;
    logic [11:0] codes [4];
    int vectors = 0;
    int miscompares = 0;
    int den_cnt = 0;
    bit drop_ch2 = 1'b0;
    bit stray = 1'b0;

    xadc_drp_sampler_if drp_if();

    xadc_drp_sampler dut (
        .clk(clk),
        .rstn(rstn),
        .eos(eos),
        .drp(drp_if),
        .dout0(dout0),
        .dout1(dout1),
        .dout2(dout2),
        .dout3(dout3),
        .dout_valid(dout_valid),
        .drp_err(drp_err)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int act, int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic logic [11:0] code_for(logic [6:0] a);
        case (a)
            7'h11: return codes[0];
            7'h10: return codes[1];
            7'h18: return codes[2];
            default: return codes[3];
        endcase
    endfunction

    // DRP responder: drdy three cycles after each den, optionally silent for VAUX8.
    initial begin
        int left;
        logic [6:0] a;
        left = 0;
        a = '0;
        drp_if.drp_drdy = 1'b0;
        drp_if.drp_do = '0;
        forever begin
            @(posedge clk);
            #1;
            drp_if.drp_drdy = 1'b0;
            if (left > 0) begin
                left--;
                if (left == 0) begin
                    drp_if.drp_drdy = 1'b1;
                    drp_if.drp_do = {code_for(a), 4'h0};
                end
            end
            if (stray) begin
                drp_if.drp_drdy = 1'b1;
                drp_if.drp_do = 16'hFFF0;
                stray = 1'b0;
            end
            if (drp_if.drp_den) begin
                a = drp_if.drp_daddr;
                left = (drop_ch2 && a == 7'h18) ? 0 : 3;
            end
        end
    end

    always @(negedge clk) begin
        if (drp_if.drp_den) begin
            den_cnt++;
            if (addr_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected den: addr 0x%0h, none expected", drp_if.drp_daddr);
            end else check("daddr", int'(drp_if.drp_daddr), int'(addr_q.pop_front()));
        end
        if (dout_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected dout_valid: got %0d/%0d/%0d/%0d, none expected", dout0, dout1, dout2, dout3);
            end else begin
                e = exp_q.pop_front();
                check("dout0", dout0, e[0]);
                check("dout1", dout1, e[1]);
                check("dout2", dout2, e[2]);
                check("dout3", dout3, e[3]);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_eos();
        eos = 1'b1;
        tick(1);
        eos = 1'b0;
    endtask

    task automatic push_addrs();
        addr_q.push_back(7'h11);
        addr_q.push_back(7'h10);
        addr_q.push_back(7'h18);
        addr_q.push_back(7'h19);
    endtask

    task automatic push_sweep(int d0, int d1, int d2, int d3);
        push_addrs();
        exp_q.push_back({16'(d3), 16'(d2), 16'(d1), 16'(d0)});
    endtask

    task automatic wait_drain(string name, int bound);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || addr_q.size() != 0) && n < bound) begin
            tick(1);
            n++;
        end
        check({name, " drain"}, exp_q.size() + addr_q.size(), 0);
        tick(8);
    endtask

    task automatic check_zero(string name);
        check({name, " dout0"}, dout0, 0);
        check({name, " dout1"}, dout1, 0);
        check({name, " dout2"}, dout2, 0);
        check({name, " dout3"}, dout3, 0);
        check({name, " dout_valid"}, dout_valid, 0);
        check({name, " drp_err"}, drp_err, 0);
        check({name, " den"}, drp_if.drp_den, 0);
    endtask

    initial begin
        int d;
        int n;
        logic [11:0] c0 [4];
        codes = '{12'h000, 12'h000, 12'h000, 12'h000};
        c0 = '{12'h800, 12'h800, 12'h801, 12'h801};
        tick(3);
        check_zero("reset");
        rstn = 1'b1;
        tick(2);
`ifdef XADC_AVG_EN
        for (int s = 0; s < 4; s++) begin
            codes = '{c0[s], 12'h400, 12'h400, 12'h400};
            if (s == 3) push_sweep(500, 250, 250, 250);
            else push_addrs();
            pulse_eos();
            wait_drain("avg sweep", 300);
        end
        check("avg drp_err", drp_err, 0);
`else
        codes = '{12'h000, 12'h800, 12'hFFF, 12'h400};
        push_sweep(0, 500, 1000, 250);
        pulse_eos();
        wait_drain("basic", 300);
        check("basic drp_err", drp_err, 0);

        codes = '{12'h800, 12'h400, 12'hC00, 12'hFFF};
        d = den_cnt;
        push_sweep(500, 250, 750, 1000);
        push_sweep(500, 250, 750, 1000);
        pulse_eos();
        tick(4);
        pulse_eos();
        tick(4);
        pulse_eos();
        wait_drain("pending", 500);
        tick(60);
        check("pending den count", den_cnt - d, 8);

        d = den_cnt;
        stray = 1'b1;
        tick(20);
        check("stray den count", den_cnt - d, 0);
        check("stray dout2 hold", dout2, 750);

        d = den_cnt;
        push_sweep(500, 250, 750, 1000);
        push_sweep(500, 250, 750, 1000);
        pulse_eos();
        tick(4);
        pulse_eos();
        n = 0;
        while (!dout_valid && n < 300) begin
            tick(1);
            n++;
        end
        check("coincide first valid", dout_valid, 1);
        eos = 1'b1;
        tick(1);
        eos = 1'b0;
        wait_drain("coincide", 500);
        tick(60);
        check("coincide den count", den_cnt - d, 8);

        codes = '{12'hFFF, 12'h800, 12'h123, 12'h000};
        drop_ch2 = 1'b1;
        push_sweep(1000, 500, 750, 0);
        pulse_eos();
        wait_drain("timeout", 1000);
        check("timeout drp_err", drp_err, 1);
        drop_ch2 = 1'b0;
`endif
        codes = '{12'h400, 12'h400, 12'h400, 12'h400};
        addr_q.push_back(7'h11);
        pulse_eos();
        tick(2);
        rstn = 1'b0;
        #1;
        check_zero("mid-wait reset");
        check("aborted addr queue", addr_q.size(), 0);
        tick(10);
        rstn = 1'b1;
        tick(2);
`ifdef XADC_AVG_EN
        for (int s = 0; s < 4; s++) begin
            if (s == 3) push_sweep(250, 250, 250, 250);
            else push_addrs();
            pulse_eos();
            wait_drain("post-reset avg", 300);
        end
`else
        push_sweep(250, 250, 250, 250);
        pulse_eos();
        wait_drain("post-reset", 300);
`endif
        check("post-reset drp_err", drp_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/xadc_drp_sampler.md
Name: xadc_drp_sampler

Overview:
- Upstream feeder of the OLED voltage display.
- Polls four XADC channel result registers over the DRP port after each end-of-sequence and converts each 12-bit code to millivolts.
- Optionally averages over several sweeps, then presents four coherent 16-bit millivolt words (din0..din3 of the display stage), updated together with a one-cycle valid strobe.

Parameters:
- CH0_ADDR, 8'h11, DRP address of channel 0 result (VAUX1).
- CH1_ADDR, 8'h10, DRP address of channel 1 result (VAUX0).
- CH2_ADDR, 8'h18, DRP address of channel 2 result (VAUX8).
- CH3_ADDR, 8'h19, DRP address of channel 3 result (VAUX9).
- FULL_SCALE_MV, 1000, millivolts represented by code 4096.
- AVG_LOG2, 2, log2 of sweeps averaged (only with XADC_AVG_EN); legal range 0..4.
- TIMEOUT_CYC, 255, max cycles waiting for drdy before a read is abandoned.

Ports:
- clk  in  1  system clock; also DRP clock.
- rstn  in  1  asynchronous active-low reset.
- eos  in  1  XADC end-of-sequence pulse.
- drp_daddr  out  7  DRP address (low 7 bits of CHn_ADDR).
- drp_den  out  1  DRP enable, one-cycle pulse per read.
- drp_dwe  out  1  DRP write enable, tied 0.
- drp_di  out  16  DRP write data, tied 0.
- drp_do  in  16  DRP read data; code in [15:4].
- drp_drdy  in  1  DRP read-data-ready.
- dout0..dout3  out  16 each  channel millivolts, 0..FULL_SCALE_MV.
- dout_valid  out  1  one-cycle pulse when dout0..3 update.
- drp_err  out  1  sticky; set on any drdy timeout; cleared only by reset.

Behaviour:
- Reset (asynchronous, rstn=0): all outputs 0, FSM in IDLE, accumulators, sweep counter and pending flag cleared.
- FSM states: IDLE, REQ, WAIT, SCALE, NEXT, PUBLISH.
- IDLE: on eos or pending=1, clear pending, set ch=0, go to REQ.
- REQ: drp_den=1 for exactly one cycle, drp_daddr=CHch_ADDR[6:0]; go to WAIT. drp_daddr is held until drdy or timeout.
- WAIT: on drdy, capture code=drp_do[15:4] and go to SCALE. If the wait counter reaches TIMEOUT_CYC, set drp_err, keep the previous value for this channel (the accumulator adds the last scaled value), and go to NEXT.
- SCALE (1 cycle): mv = (code*FULL_SCALE_MV + 2048) >> 12, 22-bit intermediate, result truncated to 16 bits. Code 0 -> 0, code 4095 -> 1000, code 2048 -> 500.
- NEXT: add mv into acc[ch]. If ch<3: ch++ and go to REQ. Else go to PUBLISH.
- PUBLISH: without averaging, doutN=acc[N] for all N, dout_valid=1 for one cycle, accumulators cleared. With averaging, see Optional Feature. Then go to IDLE.
- Latency: eos -> dout_valid is 4 reads plus 6 cycles overhead, deterministic when drdy returns in a fixed number of cycles.
- eos arriving while not in IDLE sets pending (one deep). Further eos while pending is already set are dropped. A sweep is never interrupted.
- eos and the IDLE exit coinciding in the same cycle: the sweep starts and pending stays 0.
- A drdy pulse arriving outside WAIT is ignored.
- dout0..3 change only in PUBLISH, all in the same cycle; there are no partial updates.
- Reset mid-sweep: the sweep is abandoned and all outputs return to 0.

Optional Feature:
- Macro: XADC_AVG_EN.
- Defined: acc[N] is (16+AVG_LOG2) bits. A sweep counter counts PUBLISH entries. Only on the 2^AVG_LOG2-th sweep: doutN = (acc[N] + 2^(AVG_LOG2-1)) >> AVG_LOG2, dout_valid pulses, accumulators and counter clear. On other sweeps, PUBLISH goes straight to IDLE with no output change.
- With AVG_LOG2=0: behaviour is identical to the macro being undefined.
- Undefined: no sweep counter; every sweep publishes.

Decomposition:
- Shared package xadc_pkg: state encoding localparams, DRP address constants for VAUX0/1/8/9, code width 12, mV width 16.
- One sub-module is natural: xadc_code_to_mv, a registered 1-cycle multiply-round-shift, parameterised by FULL_SCALE_MV.

Test Plan:
- Reset then eos, DRP model returning codes 0x000/0x800/0xFFF/0x400 with drdy 3 cycles after den -> dout0..3 = 0/500/1000/250, single dout_valid, exactly 4 den pulses with addresses 0x11, 0x10, 0x18, 0x19.
- Second eos during a sweep plus a third during the same sweep -> exactly one additional sweep, 8 den pulses total.
- DRP model never asserts drdy for CH2 -> drp_err=1 after 255 cycles, dout2 holds its previous value, other channels update.
- XADC_AVG_EN, AVG_LOG2=2, CH0 codes 0x800, 0x800, 0x801, 0x801 -> no dout_valid for 3 sweeps; on the 4th, dout0=500 and dout_valid=1.
- rstn low mid-WAIT -> all outputs 0 immediately; the next eos starts a clean sweep at CH0.
- Stray drdy in IDLE and the eos/IDLE-exit coincidence -> no output change, no extra sweep.
